// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one main-memory port between the i-cache (read-only) and the d-cache
// (read/writeback). Arbitration is round-robin between the two caches. A
// watchdog aborts memory transactions that run for too long and latches a
// sticky error flag.
//
// Every transaction follows the same sequence: IDLE -> GNT_x -> TURN -> IDLE.
// The single TURN cycle gives the requester time to drop its request after it
// sees busywait go low, so a finished request is never granted a second time.
module cache_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_busywait,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    TURN
  } state_t;

  // The counter only has to reach TIMEOUT; the minimum width is 1 bit.
  localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
  localparam bit WDOG_ON = (TIMEOUT != 0);

  state_t            state;
  logic              last_d;      // 1 when the d-cache had the most recent grant
  logic              seen_busy;   // memory has accepted the current transaction
  logic              grant_write; // operation latched at grant time
  logic [WDOG_W-1:0] wdog;

  logic i_req;
  logic d_req;
  logic in_grant;
  logic done;
  logic timeout;
  logic finish;

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign in_grant = (state == GNT_I) || (state == GNT_D);

  // A transaction is complete only after memory has raised busywait and then
  // lowered it again. This rejects the stale busywait=0 seen in the grant cycle.
  assign done    = in_grant & seen_busy & ~mem_busywait;
  assign timeout = WDOG_ON & in_grant & ~done & (wdog == WDOG_LIMIT);
  assign finish  = done | timeout;

  // Busywait drops for exactly the cycle in which the port's grant finishes
  // (normal completion or watchdog abort). An idle port reads busywait as 0.
  assign i_busywait = i_req & ~((state == GNT_I) & finish);
  assign d_busywait = d_req & ~((state == GNT_D) & finish);

  // Drive the memory port from the granted cache. The strobe follows the
  // operation latched at grant time, so a requester that drops its request
  // early does not cut the memory transaction short.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      GNT_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
      end
      GNT_D: begin
        mem_read      = ~grant_write;
        mem_write     = grant_write;
        mem_address   = d_address;
        mem_writedata = d_writedata;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Arbitration FSM. It also handles completion tracking, the watchdog,
  // read-data capture and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      seen_busy   <= 1'b0;
      grant_write <= 1'b0;
      wdog        <= '0;
      i_readdata  <= '0;
      d_readdata  <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          seen_busy <= 1'b0;
          wdog      <= '0;
          if (i_req && (!d_req || last_d)) begin
            state       <= GNT_I;
            last_d      <= 1'b0;
            grant_write <= 1'b0;
          end else if (d_req) begin
            state       <= GNT_D;
            last_d      <= 1'b1;
            // A read and a write together are treated as a write.
            grant_write <= d_write;
          end
        end

        GNT_I, GNT_D: begin
          wdog <= wdog + WDOG_W'(1);
          if (mem_busywait) begin
            seen_busy <= 1'b1;
          end
          if (done) begin
            state     <= TURN;
            seen_busy <= 1'b0;
            // If the requester has already withdrawn, the returned block is discarded.
            if (state == GNT_I && i_read) begin
              i_readdata <= mem_readdata;
            end
            if (state == GNT_D && !grant_write && d_read) begin
              d_readdata <= mem_readdata;
            end
          end else if (timeout) begin
            state       <= TURN;
            seen_busy   <= 1'b0;
            err_timeout <= 1'b1;
          end
        end

        TURN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Drives randomized and directed cache requests into the arbiter. A
// behavioural memory model sits behind the memory port. A transaction-level
// reference model predicts the grant order, the memory transactions, the
// returned blocks, the busywait duration and the error flag.
module tb_cache_mem_arbiter;

  localparam int AW = 28;
  localparam int BW = 128;
  localparam int TB_TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [BW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [BW-1:0] d_writedata;
  logic [BW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_writedata;
  logic [BW-1:0] mem_readdata;
  logic          mem_busywait;
  logic          err_timeout;

  cache_mem_arbiter #(
    .ADDR_W (AW),
    .BLOCK_W(BW),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
  } txn_t;

  txn_t obs_q[$];

  int total = 0;
  int bad = 0;

  // Memory model state
  int mem_lat = 1;
  int mem_cnt = 0;
  bit mem_active = 0;
  bit mem_finished = 0;
  bit mem_stuck = 0;

  // Reference model state
  bit            model_last_d;
  logic [BW-1:0] exp_i_rd;
  logic [BW-1:0] exp_d_rd;
  logic          exp_err;

  function automatic logic [BW-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural main memory. It updates just after each rising edge. When it
  // sees a strobe, it stays busy for mem_lat cycles. It then returns a random
  // block and waits for the strobes to fall before accepting new work.
  always @(posedge clk) begin
    #1;
    if (mem_active) begin
      if (!(mem_read || mem_write)) begin
        mem_active   = 0;
        mem_busywait = 1'b0;
      end else if (!mem_stuck) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          mem_active   = 0;
          mem_finished = 1;
          mem_busywait = 1'b0;
          mem_readdata = rand_block();
          if (obs_q.size() > 0) obs_q[obs_q.size()-1].rdata = mem_readdata;
        end
      end
    end else if (mem_finished) begin
      if (!(mem_read || mem_write)) mem_finished = 0;
    end else if (mem_read || mem_write) begin
      txn_t t;
      t.rd    = mem_read;
      t.wr    = mem_write;
      t.addr  = mem_address;
      t.wdata = mem_writedata;
      t.rdata = '0;
      obs_q.push_back(t);
      mem_active   = 1;
      mem_busywait = 1'b1;
      mem_cnt      = mem_lat;
    end
  end

  task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold one port's request until its busywait drops. Count the busy cycles,
  // then release the request on the following edge.
  task automatic servePort(input bit is_d, output int high, output bit expired);
    bit fin;
    high = 0;
    expired = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (is_d ? d_busywait : i_busywait) begin
        high++;
        if (high > 300) begin
          expired = 1;
          fin = 1;
        end
      end else begin
        fin = 1;
      end
    end
    @(posedge clk);
    #1;
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // One arbitration round. d_op: 0 none, 1 read, 2 write, 3 read+write.
  task automatic applyStimulus(input bit do_i, input int d_op, input logic [AW-1:0] ia,
                               input logic [AW-1:0] da, input logic [BW-1:0] wd, input int lat);
    int  hi_i, hi_d, n_exp, l;
    bit  to_i, to_d, do_d, d_first, d_wr;
    bit  order[2];
    hi_i = 0;
    hi_d = 0;
    to_i = 0;
    to_d = 0;
    do_d = (d_op != 0);
    d_wr = (d_op >= 2);
    l = lat;
    checkOutput("idle_i_busywait", {127'd0, i_busywait}, '0);
    checkOutput("idle_d_busywait", {127'd0, d_busywait}, '0);
    obs_q.delete();
    mem_lat     = lat;
    i_address   = ia;
    d_address   = da;
    d_writedata = wd;
    i_read      = do_i;
    d_read      = (d_op == 1 || d_op == 3);
    d_write     = d_wr;
    fork
      begin
        if (do_i) servePort(1'b0, hi_i, to_i);
      end
      begin
        if (do_d) servePort(1'b1, hi_d, to_d);
      end
    join

    // Reference: when both ports request, the port that was not served last goes first.
    d_first  = do_d && (!do_i || !model_last_d);
    n_exp    = (do_i ? 1 : 0) + (do_d ? 1 : 0);
    order[0] = d_first;
    order[1] = !d_first;
    checkOutput("txn_count", BW'(obs_q.size()), BW'(n_exp));
    if (obs_q.size() == n_exp) begin
      for (int k = 0; k < n_exp; k++) begin
        if (order[k]) begin
          checkOutput("d_mem_addr", {100'd0, obs_q[k].addr}, {100'd0, da});
          checkOutput("d_mem_write", {127'd0, obs_q[k].wr}, {127'd0, d_wr});
          checkOutput("d_mem_read", {127'd0, obs_q[k].rd}, {127'd0, !d_wr});
          if (d_wr) checkOutput("d_mem_wdata", obs_q[k].wdata, wd);
          else exp_d_rd = obs_q[k].rdata;
        end else begin
          checkOutput("i_mem_addr", {100'd0, obs_q[k].addr}, {100'd0, ia});
          checkOutput("i_mem_read", {126'd0, obs_q[k].rd, obs_q[k].wr}, {126'd0, 2'b10});
          exp_i_rd = obs_q[k].rdata;
        end
      end
    end
    if (do_i) begin
      checkOutput("i_wait_bound", {127'd0, to_i}, '0);
      checkOutput("i_busy_cycles", BW'(hi_i), BW'((do_d && d_first) ? 2*l + 4 : l + 1));
    end
    if (do_d) begin
      checkOutput("d_wait_bound", {127'd0, to_d}, '0);
      checkOutput("d_busy_cycles", BW'(hi_d), BW'((do_i && !d_first) ? 2*l + 4 : l + 1));
    end
    if (n_exp == 2) model_last_d = !d_first;
    else if (n_exp == 1) model_last_d = do_d;
    checkOutput("i_readdata", i_readdata, exp_i_rd);
    checkOutput("d_readdata", d_readdata, exp_d_rd);
    checkOutput("err_timeout", {127'd0, err_timeout}, {127'd0, exp_err});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    bit to;
    logic [BW-1:0] aa_blk;
    reset        = 1'b1;
    i_read       = 1'b0;
    i_address    = '0;
    d_read       = 1'b0;
    d_write      = 1'b0;
    d_address    = '0;
    d_writedata  = '0;
    mem_readdata = '0;
    mem_busywait = 1'b0;
    model_last_d = 0;
    exp_i_rd     = '0;
    exp_d_rd     = '0;
    exp_err      = 1'b0;
    $display("[TB] start");

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_read", {127'd0, mem_read}, '0);
    checkOutput("rst_mem_write", {127'd0, mem_write}, '0);
    checkOutput("rst_mem_addr", {100'd0, mem_address}, '0);
    checkOutput("rst_mem_wdata", mem_writedata, '0);
    checkOutput("rst_i_readdata", i_readdata, '0);
    checkOutput("rst_d_readdata", d_readdata, '0);
    checkOutput("rst_err", {127'd0, err_timeout}, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: lone i-cache read, d-cache writeback, contention twice, d-reads back to back
    aa_blk = {16{8'hAA}};
    applyStimulus(1, 0, 28'h10, 28'h0, '0, 5);
    applyStimulus(0, 2, 28'h0, 28'h20, aa_blk, 3);
    applyStimulus(1, 1, 28'h30, 28'h40, rand_block(), 2);
    applyStimulus(1, 1, 28'h31, 28'h41, rand_block(), 4);
    applyStimulus(0, 1, 28'h0, 28'h50, rand_block(), 1);
    applyStimulus(0, 1, 28'h0, 28'h51, rand_block(), 2);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      bit di;
      int dop;
      di  = 1'($urandom_range(0, 1));
      dop = $urandom_range(0, 3);
      if (!di && dop == 0) di = 1;
      applyStimulus(di, dop, AW'($urandom), AW'($urandom), rand_block(), $urandom_range(1, 5));
    end

    // Watchdog: memory never completes
    obs_q.delete();
    mem_stuck = 1;
    d_read    = 1'b1;
    d_address = 28'h77;
    servePort(1'b1, hi, to);
    checkOutput("wdog_bound", {127'd0, to}, '0);
    checkOutput("wdog_busy_cycles", BW'(hi), BW'(TB_TIMEOUT + 1));
    checkOutput("wdog_err", {127'd0, err_timeout}, {127'd0, 1'b1});
    checkOutput("wdog_d_readdata", d_readdata, exp_d_rd);
    repeat (2) @(posedge clk);
    #1;
    mem_stuck    = 0;
    model_last_d = 1;
    exp_err      = 1'b1;
    applyStimulus(1, 1, 28'h88, 28'h99, rand_block(), 2);
    checkOutput("wdog_err_sticky", {127'd0, err_timeout}, {127'd0, 1'b1});

    // Reset in the middle of a d-cache grant
    mem_lat   = 5;
    d_read    = 1'b1;
    d_address = 28'h66;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_mem_read", {127'd0, mem_read}, '0);
    checkOutput("midrst_mem_write", {127'd0, mem_write}, '0);
    checkOutput("midrst_i_readdata", i_readdata, '0);
    checkOutput("midrst_d_readdata", d_readdata, '0);
    checkOutput("midrst_err", {127'd0, err_timeout}, '0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    d_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_last_d = 0;
    exp_i_rd     = '0;
    exp_d_rd     = '0;
    exp_err      = 1'b0;

    // Contention after reset again favours the d-cache
    applyStimulus(1, 1, 28'h12, 28'h34, rand_block(), 3);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 3), AW'($urandom), AW'($urandom),
                    rand_block(), $urandom_range(1, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
